// File: rtl/cart_arb_pkg.sv
// Shared types for the cartridge memory arbiter: FSM states, requester IDs and latched request fields.
// The address width in req_fields_t sets the default ADDR_W of the arbiter.
package cart_arb_pkg;

    localparam int CART_ADDR_W = 22;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_LDR,
        REQ_PRG,
        REQ_CHR,
        REQ_REF
    } req_id_t;

    typedef struct packed {
        logic                   we;
        logic [CART_ADDR_W-1:0] addr;
        logic [7:0]             wdata;
    } req_fields_t;

endpackage

// File: rtl/cart_arb_req_latch.sv
// Per-requester pending flag and field capture; a req pulse sets pend one cycle later, last req wins.
// A req arriving after the grant snapshot keeps pend set through the clear so it is serviced again.
module cart_arb_req_latch
    import cart_arb_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req,
    input  logic                   we,
    input  logic [CART_ADDR_W-1:0] addr,
    input  logic [7:0]             wdata,
    input  logic                   grant,
    input  logic                   clear,
    output logic                   pend,
    output req_fields_t            fields
);

    // fresh marks a capture not yet taken by a grant snapshot
    logic fresh;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend   <= 1'b0;
            fresh  <= 1'b0;
            fields <= '0;
        end else if (req) begin
            pend   <= 1'b1;
            fresh  <= 1'b1;
            fields <= '{we: we, addr: addr, wdata: wdata};
        end else begin
            if (grant) fresh <= 1'b0;
            if (clear) pend  <= fresh;
        end
    end

endmodule

// File: rtl/cart_mem_arbiter.sv
// Shares one byte-wide cartridge memory port between loader, PRG and CHR; req pulse to done = 3 cycles + memory wait.
// Optional refresh slots with CART_ARB_REFRESH_EN; one transaction in flight, mem_req held until mem_ack.
module cart_mem_arbiter
    import cart_arb_pkg::*;
#(
    parameter int ADDR_W         = CART_ADDR_W,
    parameter int REFRESH_PERIOD = 780
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prg_req,
    input  logic              prg_we,
    input  logic [ADDR_W-1:0] prg_addr,
    input  logic [7:0]        prg_wdata,
    output logic [7:0]        prg_rdata,
    output logic              prg_done,
    input  logic              chr_req,
    input  logic              chr_we,
    input  logic [ADDR_W-1:0] chr_addr,
    input  logic [7:0]        chr_wdata,
    output logic [7:0]        chr_rdata,
    output logic              chr_done,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [7:0]        ldr_wdata,
    output logic [7:0]        ldr_rdata,
    output logic              ldr_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              mem_refresh
);

    arb_state_t  state, state_nxt;
    req_id_t     winner, sel_id;
    req_fields_t cur, sel_fields;
    req_fields_t prg_f, chr_f, ldr_f;
    logic        pend_prg, pend_chr, pend_ldr;
    logic        sel_vld, grant, finish, busy, rr_chr, refresh_pend;

    cart_arb_req_latch u_prg (
        .clk(clk), .reset(reset), .req(prg_req), .we(prg_we), .addr(prg_addr), .wdata(prg_wdata),
        .grant(grant && sel_id == REQ_PRG), .clear(finish && winner == REQ_PRG),
        .pend(pend_prg), .fields(prg_f)
    );

    cart_arb_req_latch u_chr (
        .clk(clk), .reset(reset), .req(chr_req), .we(chr_we), .addr(chr_addr), .wdata(chr_wdata),
        .grant(grant && sel_id == REQ_CHR), .clear(finish && winner == REQ_CHR),
        .pend(pend_chr), .fields(chr_f)
    );

    cart_arb_req_latch u_ldr (
        .clk(clk), .reset(reset), .req(ldr_req), .we(ldr_we), .addr(ldr_addr), .wdata(ldr_wdata),
        .grant(grant && sel_id == REQ_LDR), .clear(finish && winner == REQ_LDR),
        .pend(pend_ldr), .fields(ldr_f)
    );

`ifdef CART_ARB_REFRESH_EN
    localparam int              REF_W    = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_PERIOD - 1);
    logic [REF_W-1:0] ref_cnt;

    // A newly due refresh wins over the clear of the slot just serviced
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt      <= '0;
            refresh_pend <= 1'b0;
        end else begin
            ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + 1'b1;
            if (ref_cnt == REF_LAST)
                refresh_pend <= 1'b1;
            else if (finish && winner == REQ_REF)
                refresh_pend <= 1'b0;
        end
    end

    assign mem_refresh = busy && winner == REQ_REF;
`else
    assign refresh_pend = 1'b0;
    assign mem_refresh  = 1'b0;
`endif

    always_comb begin
        sel_vld = 1'b1;
        sel_id  = REQ_LDR;
        if (refresh_pend)
            sel_id = REQ_REF;
        else if (pend_ldr)
            sel_id = REQ_LDR;
        else if (pend_prg && (!pend_chr || !rr_chr))
            sel_id = REQ_PRG;
        else if (pend_chr)
            sel_id = REQ_CHR;
        else
            sel_vld = 1'b0;

        case (sel_id)
            REQ_LDR: sel_fields = ldr_f;
            REQ_PRG: sel_fields = prg_f;
            REQ_CHR: sel_fields = chr_f;
            default: sel_fields = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: if (sel_vld) begin
                state_nxt = ISSUE;
                grant     = 1'b1;
            end
            ISSUE: state_nxt = WAIT;
            WAIT:  if (mem_ack) state_nxt = DONE;
            DONE: begin
                state_nxt = IDLE;
                finish    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            winner    <= REQ_LDR;
            cur       <= '0;
            rr_chr    <= 1'b0;
            prg_rdata <= '0;
            chr_rdata <= '0;
            ldr_rdata <= '0;
        end else begin
            if (grant) begin
                winner <= sel_id;
                cur    <= sel_fields;
                if (sel_id == REQ_PRG || sel_id == REQ_CHR) rr_chr <= ~rr_chr;
            end
            // Read data is captured on the ack edge so it is valid alongside the done pulse
            if (state == WAIT && mem_ack && !cur.we) begin
                case (winner)
                    REQ_PRG: prg_rdata <= mem_rdata;
                    REQ_CHR: chr_rdata <= mem_rdata;
                    REQ_LDR: ldr_rdata <= mem_rdata;
                    default: ;
                endcase
            end
        end
    end

    assign busy      = (state == ISSUE) || (state == WAIT);
    assign mem_req   = busy && winner != REQ_REF;
    assign mem_we    = busy && cur.we;
    assign mem_addr  = busy ? cur.addr : '0;
    assign mem_wdata = busy ? cur.wdata : '0;
    assign prg_done  = finish && winner == REQ_PRG;
    assign chr_done  = finish && winner == REQ_CHR;
    assign ldr_done  = finish && winner == REQ_LDR;

endmodule

// File: doc/cart_mem_arbiter.md
Name: cart_mem_arbiter

Overview:
- Shares the single byte-wide cartridge memory port between three requesters: CPU PRG access, PPU CHR access, and the ROM loader.
- Sits between the mapper address outputs (PRG and CHR byte addresses) and the external memory controller.
- Latches each request, arbitrates (loader > alternating PRG/CHR), runs one memory transaction at a time with a req/ack handshake, and returns read data per requester.

Parameters:
- ADDR_W, 22, byte address width on all ports.
- REFRESH_PERIOD, 780, clk cycles between forced refresh slots (used only with CART_ARB_REFRESH_EN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- prg_req  in  1  one-cycle request pulse
- prg_we  in  1  write when 1
- prg_addr  in  ADDR_W  byte address
- prg_wdata  in  8  write data
- prg_rdata  out  8  read data, held until the next PRG read completes
- prg_done  out  1  one-cycle completion pulse
- chr_req, chr_we, chr_addr, chr_wdata, chr_rdata, chr_done: same set for the PPU
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_done: same set for the loader
- mem_req  out  1  held high until mem_ack
- mem_we  out  1  transaction direction
- mem_addr  out  ADDR_W  transaction address
- mem_wdata  out  8  transaction write data
- mem_ack  in  1  one-cycle; mem_rdata valid in the same cycle
- mem_rdata  in  8  read data
- mem_refresh  out  1  refresh request (tied 0 without the macro)

Behaviour:
- Reset values:
  - all outputs 0; pending flags cleared; FSM in IDLE
  - RR pointer = PRG; refresh counter = 0
- Pending latches:
  - Each xxx_req pulse sets pend_xxx and captures we/addr/wdata.
  - A new req while pend_xxx is set overwrites the captured fields (last wins). No second done pulse is produced.
  - A req in the same cycle its grant is issued is held for the next grant; it is not lost.
- FSM states:
  - IDLE: select a winner from the pending set; go to ISSUE the next cycle. Stay in IDLE if nothing is pending.
  - ISSUE: drive mem_req=1 with the selected fields; go to WAIT.
  - WAIT: hold mem_* stable; on mem_ack go to DONE.
  - DONE: for a read, latch mem_rdata into the winner's rdata. Pulse the winner's done; clear its pend; go to IDLE.
- Priority:
  - Loader always wins.
  - Otherwise PRG and CHR alternate via the RR pointer, which toggles after each PRG or CHR grant.
  - If only one of PRG/CHR is pending it wins regardless of the pointer.
- Latency: request pulse to done pulse = 3 cycles + memory wait. With mem_ack in the first WAIT cycle, done arrives on cycle 4 after the req pulse.
- rdata is unchanged on writes.
- mem_ack outside WAIT is ignored.
- reset asserted mid-transaction:
  - abandons it; no done pulse; mem_req drops the next cycle
  - the memory controller must tolerate the dropped request

Optional Feature:
- Macro: CART_ARB_REFRESH_EN.
- With the macro:
  - A counter counts clk cycles to REFRESH_PERIOD-1, then sets refresh_pend and wraps to 0.
  - refresh_pend outranks every requester, including the loader.
  - Its slot drives mem_refresh=1 (with mem_req=0) through ISSUE/WAIT until mem_ack. No done pulse.
  - A refresh that becomes due while another transaction is in flight waits for that transaction's DONE.
- Without the macro: mem_refresh is tied 0 and no counter is present.

Decomposition:
- Package cart_arb_pkg holds:
  - typedef enum for FSM states {IDLE, ISSUE, WAIT, DONE}
  - typedef enum for requester IDs {REQ_LDR, REQ_PRG, REQ_CHR, REQ_REF}
  - struct {we, addr, wdata}
- One sub-module, cart_arb_req_latch: per-requester pending flag plus field capture, instantiated three times.

Test Plan:
- Single PRG read to addr 0x012345; mem_ack with mem_rdata=0xA5 on the first WAIT cycle -> mem_addr=0x012345, mem_we=0; prg_done on cycle 4; prg_rdata=0xA5; chr/ldr done stay 0.
- PRG and CHR pulsed in the same cycle, both reads, after reset -> PRG is granted first, then CHR; each done pulses exactly once. A second simultaneous pair -> PRG granted first again (RR pointer back to PRG after the CHR grant).
- Loader write (addr 0x200000, data 0x3C) pulsed together with PRG and CHR reads -> loader is issued first with mem_we=1, mem_wdata=0x3C; ldr_rdata unchanged.
- PRG pulsed twice while pending (addr 0x10, then 0x20) -> one transaction to 0x20, a single prg_done.
- mem_ack delayed 10 cycles -> mem_req/mem_addr stay stable for all 10 cycles. reset asserted in WAIT -> no done pulse; all outputs 0 the next cycle.
- With CART_ARB_REFRESH_EN and REFRESH_PERIOD=16, continuous CHR traffic -> mem_refresh is asserted every 16 cycles, deferred past any in-flight CHR transaction. Without the macro -> mem_refresh stays 0.
